// File: rtl/fb_update_sequencer.sv
// Framebuffer reload sequencer: debounces the zoom switch, then on a frame
// boundary it clears the framebuffer, starts the ROM-to-RAM copier and commits
// the new display mode at the following frame boundary.
module fb_update_sequencer #(
   parameter int unsigned ADDR_W      = 19,
   parameter int unsigned CLEAR_WORDS = 76800,
   parameter int unsigned DEB_CYCLES  = 250000,
   parameter int unsigned TIMEOUT     = 262144
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              mode_sw,
   input  logic              vsync,
   input  logic              copy_done,
   output logic              copy_start,
   output logic              copy_mode,
   output logic [ADDR_W-1:0] clr_wraddr,
   output logic [7:0]        clr_data,
   output logic              clr_wren,
   output logic              wr_sel,
   output logic              disp_mode,
   output logic              disp_en,
   output logic              busy,
   output logic              err
);

   localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE        = 3'd0,
      S_WAIT_VS     = 3'd1,
      S_CLEAR       = 3'd2,
      S_COPY_START  = 3'd3,
      S_COPY_WAIT   = 3'd4,
      S_COMMIT_WAIT = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic               sw_meta_q, sw_sync_q;
   logic               deb_q, deb_d;
   logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
   logic               vsync_prev_q;
   logic               target_q, target_d;
   logic               copy_start_q, copy_start_d;
   logic               copy_mode_q, copy_mode_d;
   logic [ADDR_W-1:0]  clr_wraddr_q, clr_wraddr_d;
   logic               clr_wren_q, clr_wren_d;
   logic               wr_sel_q, wr_sel_d;
   logic               disp_mode_q, disp_mode_d;
   logic               disp_en_q, disp_en_d;
   logic               busy_q, busy_d;
   logic               err_q, err_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;

   logic vs_fall_c;
   logic clr_last_c;
   logic done_ok_c;
   logic tmo_hit_c;
   logic mode_diff_c;

   // Frame boundary, last clear word, qualified copier done, timeout expiry
   assign vs_fall_c   = vsync_prev_q & ~vsync;
   assign clr_last_c  = (clr_wraddr_q == ADDR_W'(CLEAR_WORDS - 1));
   // tmo_q is zero only in the first COPY_WAIT cycle, where a stale done is dropped
   assign done_ok_c   = copy_done & (tmo_q != '0);
   assign tmo_hit_c   = (tmo_q == TMO_W'(TIMEOUT - 1));
   assign mode_diff_c = (deb_q != disp_mode_q);

   // Debouncer: accept the synchronized switch after DEB_CYCLES stable samples
   always_comb begin
      deb_d     = deb_q;
      deb_cnt_d = '0;
      if (sw_sync_q != deb_q) begin
         if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
            deb_d = sw_sync_q;
         end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
         end
      end
   end

   // State register
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= S_WAIT_VS;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:        if (mode_diff_c) state_d = S_WAIT_VS;
         S_WAIT_VS:     if (vs_fall_c)   state_d = S_CLEAR;
         S_CLEAR:       if (clr_last_c)  state_d = S_COPY_START;
         S_COPY_START:  state_d = S_COPY_WAIT;
         S_COPY_WAIT: begin
            if (done_ok_c) begin
               state_d = S_COMMIT_WAIT;
            end else if (tmo_hit_c) begin
               state_d = S_IDLE;
            end
         end
         S_COMMIT_WAIT: if (vs_fall_c)   state_d = S_IDLE;
         default:       state_d = S_WAIT_VS;
      endcase
   end

   // Output and datapath next values; outputs are set on the transition edge
   always_comb begin
      target_d     = target_q;
      copy_start_d = 1'b0;
      copy_mode_d  = copy_mode_q;
      clr_wraddr_d = clr_wraddr_q;
      clr_wren_d   = clr_wren_q;
      wr_sel_d     = wr_sel_q;
      disp_mode_d  = disp_mode_q;
      disp_en_d    = disp_en_q;
      busy_d       = busy_q;
      err_d        = err_q;
      tmo_d        = tmo_q;
      case (state_q)
         S_IDLE: begin
            busy_d     = 1'b0;
            wr_sel_d   = 1'b0;
            clr_wren_d = 1'b0;
            if (mode_diff_c) begin
               target_d = deb_q;
               busy_d   = 1'b1;
            end
         end
         S_WAIT_VS: begin
            if (vs_fall_c) begin
               disp_en_d    = 1'b0;
               clr_wraddr_d = '0;
               clr_wren_d   = 1'b1;
            end
         end
         S_CLEAR: begin
            if (clr_last_c) begin
               clr_wren_d   = 1'b0;
               copy_start_d = 1'b1;
               copy_mode_d  = target_q;
               wr_sel_d     = 1'b1;
            end else begin
               clr_wraddr_d = clr_wraddr_q + ADDR_W'(1);
            end
         end
         S_COPY_START: begin
            tmo_d = '0;
         end
         S_COPY_WAIT: begin
            if (!done_ok_c) begin
               if (tmo_hit_c) begin
                  err_d    = 1'b1;
                  wr_sel_d = 1'b0;
                  busy_d   = 1'b0;
               end else begin
                  tmo_d = tmo_q + TMO_W'(1);
               end
            end
         end
         S_COMMIT_WAIT: begin
            if (vs_fall_c) begin
               disp_mode_d = target_q;
               disp_en_d   = 1'b1;
               err_d       = 1'b0;
               wr_sel_d    = 1'b0;
               busy_d      = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clock) begin
      if (!reset) begin
         sw_meta_q    <= 1'b0;
         sw_sync_q    <= 1'b0;
         deb_q        <= 1'b0;
         deb_cnt_q    <= '0;
         vsync_prev_q <= 1'b1;
         target_q     <= 1'b0;
         copy_start_q <= 1'b0;
         copy_mode_q  <= 1'b0;
         clr_wraddr_q <= '0;
         clr_wren_q   <= 1'b0;
         wr_sel_q     <= 1'b0;
         disp_mode_q  <= 1'b0;
         disp_en_q    <= 1'b0;
         busy_q       <= 1'b1;
         err_q        <= 1'b0;
         tmo_q        <= '0;
      end else begin
         sw_meta_q    <= mode_sw;
         sw_sync_q    <= sw_meta_q;
         deb_q        <= deb_d;
         deb_cnt_q    <= deb_cnt_d;
         vsync_prev_q <= vsync;
         target_q     <= target_d;
         copy_start_q <= copy_start_d;
         copy_mode_q  <= copy_mode_d;
         clr_wraddr_q <= clr_wraddr_d;
         clr_wren_q   <= clr_wren_d;
         wr_sel_q     <= wr_sel_d;
         disp_mode_q  <= disp_mode_d;
         disp_en_q    <= disp_en_d;
         busy_q       <= busy_d;
         err_q        <= err_d;
         tmo_q        <= tmo_d;
      end
   end

   assign copy_start = copy_start_q;
   assign copy_mode  = copy_mode_q;
   assign clr_wraddr = clr_wraddr_q;
   assign clr_data   = 8'h00;
   assign clr_wren   = clr_wren_q;
   assign wr_sel     = wr_sel_q;
   assign disp_mode  = disp_mode_q;
   assign disp_en    = disp_en_q;
   assign busy       = busy_q;
   assign err        = err_q;

endmodule

// File: tb/tb_fb_update_sequencer.sv
// Bench for fb_update_sequencer with small clear/debounce/timeout parameters.
module tb_fb_update_sequencer;

   localparam int unsigned ADDR_W      = 19;
   localparam int unsigned CLEAR_WORDS = 8;
   localparam int unsigned DEB_CYCLES  = 4;
   localparam int unsigned TIMEOUT     = 32;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              mode_sw = 1'b0;
   logic              vsync = 1'b1;
   logic              copy_done = 1'b0;
   logic              copy_start;
   logic              copy_mode;
   logic [ADDR_W-1:0] clr_wraddr;
   logic [7:0]        clr_data;
   logic              clr_wren;
   logic              wr_sel;
   logic              disp_mode;
   logic              disp_en;
   logic              busy;
   logic              err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [7:0]        data;
   } wr_t;

   typedef struct {
      logic sw;
      int   hold;
      logic upd;
      logic exp_disp;
   } vec_t;

   wr_t  exp_q[$];
   logic cs_q[$];
   wr_t  mon_w;
   logic mon_m;
   vec_t vt[5];
   logic cur_sw;

   fb_update_sequencer #(
      .ADDR_W      (ADDR_W),
      .CLEAR_WORDS (CLEAR_WORDS),
      .DEB_CYCLES  (DEB_CYCLES),
      .TIMEOUT     (TIMEOUT)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .mode_sw    (mode_sw),
      .vsync      (vsync),
      .copy_done  (copy_done),
      .copy_start (copy_start),
      .copy_mode  (copy_mode),
      .clr_wraddr (clr_wraddr),
      .clr_data   (clr_data),
      .clr_wren   (clr_wren),
      .wr_sel     (wr_sel),
      .disp_mode  (disp_mode),
      .disp_en    (disp_en),
      .busy       (busy),
      .err        (err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Scoreboard consumer: every clear write and start pulse must match a queued expectation
   always @(negedge clock) begin
      if (clr_wren === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("clr_unexpected", 32'(clr_wraddr), 32'hFFFF_FFFF);
         end else begin
            mon_w = exp_q.pop_front();
            chk("clr_addr", 32'(clr_wraddr), 32'(mon_w.addr));
            chk("clr_data", 32'(clr_data), 32'(mon_w.data));
            chk("clr_wrsel", 32'(wr_sel), 0);
         end
      end
      if (copy_start === 1'b1) begin
         if (cs_q.size() == 0) begin
            chk("start_unexpected", 32'(copy_start), 0);
         end else begin
            mon_m = cs_q.pop_front();
            chk("start_mode", 32'(copy_mode), 32'(mon_m));
         end
      end
   end

   task automatic chk_reset(input string tag);
      chk({tag, "_busy"}, 32'(busy), 1);
      chk({tag, "_disp_en"}, 32'(disp_en), 0);
      chk({tag, "_wr_sel"}, 32'(wr_sel), 0);
      chk({tag, "_copy_start"}, 32'(copy_start), 0);
      chk({tag, "_copy_mode"}, 32'(copy_mode), 0);
      chk({tag, "_clr_wren"}, 32'(clr_wren), 0);
      chk({tag, "_clr_addr"}, 32'(clr_wraddr), 0);
      chk({tag, "_disp_mode"}, 32'(disp_mode), 0);
      chk({tag, "_err"}, 32'(err), 0);
   endtask

   task automatic wait_busy(input int max_ticks);
      int n;
      n = 0;
      while (busy !== 1'b1 && n < max_ticks) begin
         tick();
         n++;
      end
      chk("busy_rise", 32'(busy), 1);
   endtask

   // Drive a debounced switch change from IDLE and wait for the update to start
   task automatic raise_update(input logic sw);
      mode_sw = sw;
      repeat (5) tick();
      chk("deb_early", 32'(busy), 0);
      wait_busy(4);
   endtask

   // From WAIT_VS: frame edge, full clear, start pulse; returns in first COPY_WAIT cycle
   task automatic start_load(input logic mode, input logic flip);
      wr_t w;
      for (int a = 0; a < int'(CLEAR_WORDS); a++) begin
         w.addr = ADDR_W'(a);
         w.data = 8'h00;
         exp_q.push_back(w);
      end
      cs_q.push_back(mode);
      chk("wait_vs_no_wren", 32'(clr_wren), 0);
      vsync = 1'b0;
      tick();
      vsync = 1'b1;
      chk("clr_first_wren", 32'(clr_wren), 1);
      chk("clr_first_addr", 32'(clr_wraddr), 0);
      chk("clr_blank", 32'(disp_en), 0);
      if (flip) mode_sw = ~mode_sw;
      repeat (CLEAR_WORDS) tick();
      chk("start_pulse", 32'(copy_start), 1);
      chk("start_wrsel", 32'(wr_sel), 1);
      chk("start_copy_mode", 32'(copy_mode), 32'(mode));
      chk("start_wren_off", 32'(clr_wren), 0);
      chk("clr_addr_hold", 32'(clr_wraddr), CLEAR_WORDS - 1);
      tick();
      chk("start_one_cycle", 32'(copy_start), 0);
      chk("copy_wrsel", 32'(wr_sel), 1);
   endtask

   // Copier reports done, then the next frame edge commits the mode
   task automatic finish_commit(input logic mode);
      copy_done = 1'b1;
      repeat (4) tick();
      chk("pre_commit_wrsel", 32'(wr_sel), 1);
      chk("pre_commit_dispen", 32'(disp_en), 0);
      chk("pre_commit_busy", 32'(busy), 1);
      vsync = 1'b0;
      tick();
      vsync = 1'b1;
      chk("commit_mode", 32'(disp_mode), 32'(mode));
      chk("commit_en", 32'(disp_en), 1);
      chk("commit_busy", 32'(busy), 0);
      chk("commit_err", 32'(err), 0);
      chk("commit_wrsel", 32'(wr_sel), 0);
      chk("commit_copy_mode", 32'(copy_mode), 32'(mode));
      copy_done = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{sw: 1'b1, hold: 3, upd: 1'b0, exp_disp: 1'b0};
      vt[1] = '{sw: 1'b1, hold: 0, upd: 1'b1, exp_disp: 1'b1};
      vt[2] = '{sw: 1'b0, hold: 3, upd: 1'b0, exp_disp: 1'b1};
      vt[3] = '{sw: 1'b0, hold: 0, upd: 1'b1, exp_disp: 1'b0};
      vt[4] = '{sw: 1'b1, hold: 0, upd: 1'b1, exp_disp: 1'b1};
      cur_sw = 1'b0;

      // Power-on reset, then the initial mode-0 load at cycle 10
      repeat (3) tick();
      chk_reset("rst");
      reset = 1'b1;
      repeat (9) tick();
      chk("por_busy", 32'(busy), 1);
      start_load(1'b0, 1'b0);
      finish_commit(1'b0);

      // Switch patterns: glitches must not update, held changes must
      for (int i = 0; i < 5; i++) begin
         if (!vt[i].upd) begin
            mode_sw = vt[i].sw;
            repeat (vt[i].hold) tick();
            mode_sw = cur_sw;
            repeat (12) tick();
            chk("glitch_busy", 32'(busy), 0);
         end else begin
            cur_sw = vt[i].sw;
            raise_update(vt[i].sw);
            start_load(vt[i].sw, 1'b0);
            finish_commit(vt[i].sw);
         end
         chk("tbl_disp_mode", 32'(disp_mode), 32'(vt[i].exp_disp));
      end

      // Stale copy_done held across the start pulse is ignored for one cycle
      raise_update(1'b0);
      copy_done = 1'b1;
      start_load(1'b0, 1'b0);
      tick();
      copy_done = 1'b0;
      vsync = 1'b0;
      tick();
      vsync = 1'b1;
      chk("stale_done_mode", 32'(disp_mode), 1);
      chk("stale_done_en", 32'(disp_en), 0);
      repeat (4) tick();
      finish_commit(1'b0);

      // Toggle 0->1->0 with the return mid-clear: commit 1, then commit 0
      raise_update(1'b1);
      start_load(1'b1, 1'b1);
      finish_commit(1'b1);
      chk("toggle_retrigger", 32'(busy), 1);
      start_load(1'b0, 1'b0);
      finish_commit(1'b0);

      // Copy timeout: err after 32 COPY_WAIT cycles, then automatic retry
      raise_update(1'b1);
      start_load(1'b1, 1'b0);
      repeat (TIMEOUT - 1) tick();
      chk("tmo_err_early", 32'(err), 0);
      chk("tmo_wrsel_early", 32'(wr_sel), 1);
      tick();
      chk("tmo_err", 32'(err), 1);
      chk("tmo_wrsel", 32'(wr_sel), 0);
      chk("tmo_busy", 32'(busy), 0);
      chk("tmo_disp_mode", 32'(disp_mode), 0);
      chk("tmo_disp_en", 32'(disp_en), 0);
      tick();
      chk("tmo_retry_busy", 32'(busy), 1);
      chk("tmo_err_sticky", 32'(err), 1);
      start_load(1'b1, 1'b0);
      finish_commit(1'b1);

      // Reset in COPY_WAIT abandons the copy and reloads mode 0
      raise_update(1'b0);
      start_load(1'b0, 1'b0);
      repeat (2) tick();
      reset = 1'b0;
      tick();
      chk_reset("midrst");
      reset = 1'b1;
      tick();
      chk("midrst_busy", 32'(busy), 1);
      start_load(1'b0, 1'b0);
      finish_commit(1'b0);

      repeat (4) tick();
      chk("clr_queue_empty", 32'(exp_q.size()), 0);
      chk("start_queue_empty", 32'(cs_q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
